// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared types, mode encodings and one-hot helpers for the voting machine
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ARMED        = 2'd1,
    DEBOUNCE     = 2'd2,
    WAIT_RELEASE = 2'd3
  } vote_state_t;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  // Helpers take the widest supported button vector; callers zero-extend.
  localparam int MAX_CAND  = 32;
  localparam int MAX_IDX_W = 5;
  localparam logic [MAX_CAND-1:0] ONE_VEC = 1;

  function automatic logic is_onehot(input logic [MAX_CAND-1:0] vec);
    return (vec != '0) && ((vec & (vec - ONE_VEC)) == '0);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CAND-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/evm_btn_filter.sv
// rtl/evm_btn_filter.sv - button one-hot check, code latch, debounce counter and release detect
module evm_btn_filter
  import evm_pkg::*;
#(
  parameter int NUM_CAND     = 6,
  parameter int DEBOUNCE_CYC = 10,
  parameter int IDX_W        = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_CAND-1:0] cand_btn,
  input  logic                load,
  input  logic                hold,
  output logic                btn_idle,
  output logic                btn_single,
  output logic                press_multi,
  output logic                press_same,
  output logic                press_valid,
  output logic [IDX_W-1:0]    press_idx
);

  localparam int CNT_BITS = $clog2(DEBOUNCE_CYC + 1);
  // The vote commits on the edge where the count would reach DEBOUNCE_CYC.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYC - 1);

  logic [NUM_CAND-1:0] code;
  logic [CNT_BITS-1:0] cnt;
  logic [MAX_CAND-1:0] btn_ext;

  assign btn_ext     = MAX_CAND'(cand_btn);
  assign btn_idle    = (cand_btn == '0);
  assign btn_single  = is_onehot(btn_ext);
  assign press_multi = !btn_idle && !btn_single;
  assign press_same  = (cand_btn == code);
  assign press_valid = press_same && (cnt == CNT_LAST);

  // Latch a fresh single-button code with count 1, or extend the stable run.
  always_ff @(posedge clock) begin
    if (reset) begin
      code      <= '0;
      cnt       <= '0;
      press_idx <= '0;
    end else if (load) begin
      code      <= cand_btn;
      cnt       <= CNT_BITS'(1);
      press_idx <= IDX_W'(onehot_to_idx(btn_ext));
    end else if (hold) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/evm_param.sv
// rtl/evm_param.sv - parametrised voting machine: ballot FSM, tallies, display mux, winner
module evm_param
  import evm_pkg::*;
#(
  parameter int NUM_CAND     = 6,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 10,
  localparam int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   voter_enable,
  input  logic [NUM_CAND-1:0]    cand_btn,
  output logic                   ballot_armed,
  output logic                   vote_accepted,
  output logic                   invalid_press,
  output logic [CNT_W-1:0]       result,
  output logic [IDX_W-1:0]       sel_idx,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   winner_valid,
  output logic                   tie,
  output logic [CNT_W+IDX_W-1:0] total_votes
);

  localparam int TOT_W = CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  vote_state_t state, state_nxt;
  logic armed_nxt, load, hold, do_vote, do_inv;
  logic btn_idle, btn_single, press_multi, press_same, press_valid;
  logic [IDX_W-1:0] press_idx, btn_idx;
  logic [CNT_W-1:0] tally [NUM_CAND];
  logic prev_mode;
  logic [NUM_CAND-1:0] prev_btn;
  logic [CNT_W-1:0] best_val;
  logic [IDX_W-1:0] best_idx;
  logic best_dup;
  logic [TOT_W-1:0] sum;

  evm_btn_filter #(
    .NUM_CAND    (NUM_CAND),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .IDX_W       (IDX_W)
  ) u_filter (
    .clock      (clock),
    .reset      (reset),
    .cand_btn   (cand_btn),
    .load       (load),
    .hold       (hold),
    .btn_idle   (btn_idle),
    .btn_single (btn_single),
    .press_multi(press_multi),
    .press_same (press_same),
    .press_valid(press_valid),
    .press_idx  (press_idx)
  );

  assign btn_idx = IDX_W'(onehot_to_idx(MAX_CAND'(cand_btn)));

  // Ballot state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode; a completing debounce wins over a mode change.
  always_comb begin
    state_nxt = state;
    armed_nxt = ballot_armed;
    load      = 1'b0;
    hold      = 1'b0;
    do_vote   = 1'b0;
    do_inv    = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_VOTE && voter_enable) begin
          state_nxt = ARMED;
          armed_nxt = 1'b1;
        end
      end
      ARMED: begin
        if (mode == MODE_RESULT) begin
          state_nxt = WAIT_RELEASE;
        end else if (press_multi) begin
          do_inv    = 1'b1;
          state_nxt = WAIT_RELEASE;
        end else if (btn_single) begin
          load      = 1'b1;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (press_valid) begin
          do_vote   = 1'b1;
          armed_nxt = 1'b0;
          state_nxt = WAIT_RELEASE;
        end else if (mode == MODE_RESULT) begin
          state_nxt = WAIT_RELEASE;
        end else if (btn_idle) begin
          state_nxt = ARMED;
        end else if (press_same) begin
          hold = 1'b1;
        end else if (btn_single) begin
          load = 1'b1;
        end else begin
          do_inv    = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (mode == MODE_VOTE && btn_idle) begin
          state_nxt = ballot_armed ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Armed flag, event pulses and saturating tallies.
  always_ff @(posedge clock) begin
    if (reset) begin
      ballot_armed  <= 1'b0;
      vote_accepted <= 1'b0;
      invalid_press <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      ballot_armed  <= armed_nxt;
      vote_accepted <= do_vote;
      invalid_press <= do_inv;
      if (do_vote && tally[press_idx] != TALLY_MAX) begin
        tally[press_idx] <= tally[press_idx] + 1'b1;
      end
    end
  end

  // Result-mode display selection and registered readout.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_mode <= MODE_VOTE;
      prev_btn  <= '0;
      sel_idx   <= '0;
      result    <= '0;
    end else begin
      prev_mode <= mode;
      prev_btn  <= cand_btn;
      if (mode == MODE_RESULT) begin
        if (prev_mode != MODE_RESULT) begin
          sel_idx <= '0;
        end else if (btn_single && ((cand_btn & ~prev_btn) != '0)) begin
          sel_idx <= btn_idx;
        end
      end
      result <= (mode == MODE_RESULT) ? tally[sel_idx] : '0;
    end
  end

  // Maximum search keeps the lowest index; any later equal value marks a duplicate.
  always_comb begin
    best_val = '0;
    best_idx = '0;
    best_dup = 1'b0;
    sum      = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      sum = sum + TOT_W'(tally[i]);
      if (tally[i] > best_val) begin
        best_val = tally[i];
        best_idx = IDX_W'(i);
        best_dup = 1'b0;
      end else if (tally[i] == best_val) begin
        best_dup = 1'b1;
      end
    end
  end

  // Register the winner summary every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      winner_idx   <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
      total_votes  <= '0;
    end else begin
      winner_idx   <= best_idx;
      winner_valid <= (best_val != '0);
      tie          <= best_dup && (best_val != '0);
      total_votes  <= sum;
    end
  end

endmodule

// File: tb/tb_evm_param.sv
// tb/tb_evm_param.sv - directed table plus randomized checks of evm_param against a behavioural model
module tb_evm_param;

  localparam int NC  = 6;
  localparam int DEB = 10;

  logic clock = 1'b0;
  logic reset, mode, voter_enable;
  logic [NC-1:0] cand_btn;

  logic armed_m, acc_m, inv_m, wv_m, tie_m;
  logic [7:0] res_m;
  logic [2:0] sel_m, win_m;
  logic [10:0] tot_m;

  logic armed_s, acc_s, inv_s, wv_s, tie_s;
  logic [1:0] res_s;
  logic [2:0] sel_s, win_s;
  logic [4:0] tot_s;

  evm_param #(.NUM_CAND(NC), .CNT_W(8), .DEBOUNCE_CYC(DEB)) dut (
    .clock(clock), .reset(reset), .mode(mode), .voter_enable(voter_enable),
    .cand_btn(cand_btn), .ballot_armed(armed_m), .vote_accepted(acc_m),
    .invalid_press(inv_m), .result(res_m), .sel_idx(sel_m), .winner_idx(win_m),
    .winner_valid(wv_m), .tie(tie_m), .total_votes(tot_m)
  );

  evm_param #(.NUM_CAND(NC), .CNT_W(2), .DEBOUNCE_CYC(DEB)) dut_sat (
    .clock(clock), .reset(reset), .mode(mode), .voter_enable(voter_enable),
    .cand_btn(cand_btn), .ballot_armed(armed_s), .vote_accepted(acc_s),
    .invalid_press(inv_s), .result(res_s), .sel_idx(sel_s), .winner_idx(win_s),
    .winner_valid(wv_s), .tie(tie_s), .total_votes(tot_s)
  );

  always #5 clock = ~clock;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ballot bookkeeping as flags plus the length of the current stable run.
  int t_main [NC];
  int t_sat  [NC];
  bit m_armed, m_blocked, m_prev_mode;
  int m_run, m_sel;
  logic [NC-1:0] m_code, m_prev_btn;
  int e_armed, e_acc, e_inv, e_sel, e_res, e_res2;
  int e_win, e_wv, e_tie, e_tot, e_win2, e_wv2, e_tie2, e_tot2;

  function automatic int idx_of(input logic [NC-1:0] b);
    int r;
    r = 0;
    for (int i = 0; i < NC; i++) if (b[i]) r = i;
    return r;
  endfunction

  task automatic score(input bit sat, output int w, output int wv, output int tie_o, output int tot);
    int mx, cnt, v;
    mx = 0; cnt = 0; w = 0; tot = 0;
    for (int i = 0; i < NC; i++) begin
      v = sat ? t_sat[i] : t_main[i];
      tot += v;
      if (v > mx) mx = v;
    end
    for (int i = 0; i < NC; i++) begin
      v = sat ? t_sat[i] : t_main[i];
      if (v == mx) begin
        if (cnt == 0) w = i;
        cnt++;
      end
    end
    wv    = (mx > 0) ? 1 : 0;
    tie_o = (mx > 0 && cnt > 1) ? 1 : 0;
  endtask

  task automatic cast_vote(input int i);
    t_main[i] = (t_main[i] < 255) ? t_main[i] + 1 : 255;
    t_sat[i]  = (t_sat[i] < 3) ? t_sat[i] + 1 : 3;
  endtask

  task automatic model_edge(input bit rst, input bit m, input bit ve, input logic [NC-1:0] b);
    int pc;
    e_acc = 0;
    e_inv = 0;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin t_main[i] = 0; t_sat[i] = 0; end
      m_armed = 0; m_blocked = 0; m_run = 0; m_code = '0;
      m_sel = 0; m_prev_mode = 0; m_prev_btn = '0;
      e_armed = 0; e_sel = 0; e_res = 0; e_res2 = 0;
      e_win = 0; e_wv = 0; e_tie = 0; e_tot = 0;
      e_win2 = 0; e_wv2 = 0; e_tie2 = 0; e_tot2 = 0;
      return;
    end
    e_res  = m ? t_main[m_sel] : 0;
    e_res2 = m ? t_sat[m_sel] : 0;
    score(1'b0, e_win, e_wv, e_tie, e_tot);
    score(1'b1, e_win2, e_wv2, e_tie2, e_tot2);
    pc = $countones(b);
    if (m && !m_prev_mode) m_sel = 0;
    else if (m && pc == 1 && (b & ~m_prev_btn) != '0) m_sel = idx_of(b);
    m_prev_mode = m;
    m_prev_btn  = b;
    if (m_blocked) begin
      if (!m && pc == 0) m_blocked = 0;
    end else if (m_run > 0) begin
      if (b == m_code && m_run + 1 == DEB) begin
        cast_vote(idx_of(m_code));
        e_acc = 1; m_armed = 0; m_blocked = 1; m_run = 0;
      end else if (m) begin
        m_blocked = 1; m_run = 0;
      end else if (pc == 0) begin
        m_run = 0;
      end else if (b == m_code) begin
        m_run++;
      end else if (pc == 1) begin
        m_code = b; m_run = 1;
      end else begin
        e_inv = 1; m_blocked = 1; m_run = 0;
      end
    end else if (m_armed) begin
      if (m) m_blocked = 1;
      else if (pc > 1) begin e_inv = 1; m_blocked = 1; end
      else if (pc == 1) begin m_code = b; m_run = 1; end
    end else begin
      if (!m && ve) m_armed = 1;
    end
    e_armed = m_armed;
    e_sel   = m_sel;
  endtask

  task automatic cycle(input bit rst, input bit m, input bit ve, input logic [NC-1:0] b);
    reset = rst; mode = m; voter_enable = ve; cand_btn = b;
    @(posedge clock);
    model_edge(rst, m, ve, b);
    #1;
    check("armed",     armed_m, e_armed);
    check("accepted",  acc_m,   e_acc);
    check("invalid",   inv_m,   e_inv);
    check("sel_idx",   sel_m,   e_sel);
    check("result",    res_m,   e_res);
    check("winner",    win_m,   e_win);
    check("win_valid", wv_m,    e_wv);
    check("tie",       tie_m,   e_tie);
    check("total",     tot_m,   e_tot);
    check("sat_armed", armed_s, e_armed);
    check("sat_acc",   acc_s,   e_acc);
    check("sat_inv",   inv_s,   e_inv);
    check("sat_res",   res_s,   e_res2);
    check("sat_win",   win_s,   e_win2);
    check("sat_wv",    wv_s,    e_wv2);
    check("sat_tie",   tie_s,   e_tie2);
    check("sat_total", tot_s,   e_tot2);
  endtask

  typedef struct {
    bit rst; bit m; bit ve; logic [NC-1:0] b; int n;
    int e_armed; int e_acc; int e_inv; int e_tot; int e_win;
    int e_tie; int e_wv; int e_sel; int e_res;
  } step_t;

  localparam int NSTEP = 30;
  step_t tbl [NSTEP];

  initial begin
    int na, ni, run;
    logic [NC-1:0] rb, one;
    bit rm;

    //          rst m ve btn        n    arm acc inv tot win tie wv sel res
    tbl[0]  = '{1, 0, 0, 6'b000000, 2,   0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 6'b000000, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 6'b000001, 11,  0, 1, 0, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 6'b000001, 200, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 6'b000000, 2,   0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 6'b000000, 1,   1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 6'b000010, 5,   1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 6'b000000, 1,   1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 6'b000110, 1,   1, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 6'b000000, 2,   1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 6'b000001, 12,  0, 1, 0, 2, 0, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 1, 6'b000000, 2,   1, 0, 0, 2, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 6'b000010, 12,  0, 1, 0, 3, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 6'b000000, 1,   0, 0, 0, 3, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 6'b000000, 2,   0, 0, 0, 3, 0, 0, 1, 0, 2};
    tbl[15] = '{0, 1, 0, 6'b000010, 2,   0, 0, 0, 3, 0, 0, 1, 1, 1};
    tbl[16] = '{0, 1, 0, 6'b000000, 1,   0, 0, 0, 3, 0, 0, 1, 1, 1};
    tbl[17] = '{1, 0, 0, 6'b000000, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 1, 6'b000000, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 6'b000100, 12,  0, 1, 0, 1, 2, 0, 1, 0, 0};
    tbl[20] = '{0, 0, 1, 6'b000000, 2,   1, 0, 0, 1, 2, 0, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 6'b010000, 12,  0, 1, 0, 2, 2, 1, 1, 0, 0};
    tbl[22] = '{0, 0, 0, 6'b000000, 1,   0, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[23] = '{0, 0, 1, 6'b000000, 1,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[24] = '{0, 0, 0, 6'b001000, 6,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[25] = '{0, 1, 0, 6'b001000, 5,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[26] = '{0, 0, 0, 6'b001000, 2,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[27] = '{0, 0, 0, 6'b000000, 2,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[28] = '{0, 0, 0, 6'b001000, 4,   1, 0, 0, 2, 2, 1, 1, 0, 0};
    tbl[29] = '{1, 0, 0, 6'b001000, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; mode = 1'b0; voter_enable = 1'b0; cand_btn = '0;

    for (int s = 0; s < NSTEP; s++) begin
      na = 0; ni = 0;
      for (int k = 0; k < tbl[s].n; k++) begin
        cycle(tbl[s].rst, tbl[s].m, tbl[s].ve, tbl[s].b);
        na += int'(acc_m);
        ni += int'(inv_m);
      end
      check($sformatf("step%0d_armed", s),  armed_m, tbl[s].e_armed);
      check($sformatf("step%0d_votes", s),  na,      tbl[s].e_acc);
      check($sformatf("step%0d_invalid", s), ni,     tbl[s].e_inv);
      check($sformatf("step%0d_total", s),  tot_m,   tbl[s].e_tot);
      check($sformatf("step%0d_winner", s), win_m,   tbl[s].e_win);
      check($sformatf("step%0d_tie", s),    tie_m,   tbl[s].e_tie);
      check($sformatf("step%0d_wvalid", s), wv_m,    tbl[s].e_wv);
      check($sformatf("step%0d_sel", s),    sel_m,   tbl[s].e_sel);
      check($sformatf("step%0d_result", s), res_m,   tbl[s].e_res);
    end

    // Four ballots for candidate 3: the 2-bit tally pins at 3 yet every ballot is consumed.
    for (int v = 0; v < 4; v++) begin
      cycle(1'b0, 1'b0, 1'b1, 6'b000000);
      check($sformatf("sat_vote%0d_armed", v), armed_s, 1);
      na = 0;
      for (int k = 0; k < 12; k++) begin
        cycle(1'b0, 1'b0, 1'b0, 6'b001000);
        na += int'(acc_s);
      end
      check($sformatf("sat_vote%0d_pulses", v), na, 1);
      check($sformatf("sat_vote%0d_consumed", v), armed_s, 0);
      cycle(1'b0, 1'b0, 1'b0, 6'b000000);
    end
    cycle(1'b0, 1'b1, 1'b0, 6'b000000);
    cycle(1'b0, 1'b1, 1'b0, 6'b001000);
    cycle(1'b0, 1'b1, 1'b0, 6'b001000);
    check("sat_sel3", sel_s, 3);
    check("sat_tally3", res_s, 3);
    check("main_tally3", res_m, 4);
    check("sat_total_pinned", tot_s, 3);
    check("sat_winner3", win_s, 3);

    // Randomized runs of held buttons, with occasional mode flips, arming and resets.
    run = 0; rb = '0; rm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        run = $urandom_range(1, 14);
        case ($urandom_range(0, 3))
          0: rb = '0;
          1, 2: begin one = 6'b000001; rb = one << $urandom_range(0, NC - 1); end
          default: rb = NC'($urandom);
        endcase
      end
      run--;
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      cycle(($urandom_range(0, 799) == 0), rm, ($urandom_range(0, 9) < 3), rb);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
